alu_arb: RTL and testbench

Two-requester arbiter and sequencer for the shared 64-bit integer ALU in the execute stage. It accepts operations from two independent requesters over valid/ready handshakes and picks one per cycle, round-robin or fixed-priority. The winner is registered into an issue stage that drives an internally instantiated `ex` datapath. Results return through a registered response port tagged with the originating requester. The pipeline is fully pipelined, with one accept per cycle and two cycles from accept to response.

---
 rtl/alu_arb.sv | 152 +++++++++++++++
 tb/tb_alu_arb.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_arb.sv
// Two-requester arbiter feeding a shared 64-bit ALU through an issue (S1) and a response (S2) register.
// Define ALU_ARB_RR_EN for round-robin contention; otherwise requester 0 has fixed priority.

module ex (
    input  logic        rst,
    input  logic [7:0]  aluop,
    input  logic [3:0]  alusel,
    input  logic [63:0] op1,
    input  logic [63:0] op2,
    output logic [63:0] result,
    output logic        illegal
);
    localparam logic [3:0] RISCV_ALU_ADD = 4'h0;
    localparam logic [3:0] RISCV_ALU_SUB = 4'h1;
    localparam logic [3:0] RISCV_ALU_XOR = 4'h2;
    localparam logic [3:0] RISCV_ALU_OR  = 4'h3;
    localparam logic [3:0] RISCV_ALU_AND = 4'h4;

    // aluop only qualifies word-size variants upstream; this ALU is 64-bit only
    logic unused_aluop;
    assign unused_aluop = ^aluop;

    always_comb begin
        result  = op1;
        illegal = 1'b0;
        case (alusel)
            RISCV_ALU_ADD: result = op1 + op2;
            RISCV_ALU_SUB: result = op1 - op2;
            RISCV_ALU_XOR: result = op1 ^ op2;
            RISCV_ALU_OR:  result = op1 | op2;
            RISCV_ALU_AND: result = op1 & op2;
            default:       illegal = 1'b1;
        endcase
        if (rst) result = '0;
    end
endmodule

module alu_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_op1,
    input  logic [63:0]      req0_op2,
    input  logic [7:0]       req0_aluop,
    input  logic [3:0]       req0_alusel,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_op1,
    input  logic [63:0]      req1_op2,
    input  logic [7:0]       req1_aluop,
    input  logic [3:0]       req1_alusel,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [63:0]      rsp_result,
    output logic             rsp_illegal
);
    logic             s1_valid_q, s1_valid_d, s1_id_q;
    logic [63:0]      s1_op1_q, s1_op2_q;
    logic [7:0]       s1_aluop_q;
    logic [3:0]       s1_alusel_q;
    logic [TAG_W-1:0] s1_tag_q;

    logic             rsp_valid_q, rsp_valid_d, rsp_id_q, rsp_illegal_q;
    logic [TAG_W-1:0] rsp_tag_q;
    logic [63:0]      rsp_result_q;

    logic s2_adv, s1_free, pick0, pick1, accept;
    logic [63:0] ex_result;
    logic        ex_illegal;

    assign s2_adv  = s1_valid_q && (!rsp_valid_q || rsp_ready);
    assign s1_free = !s1_valid_q || s2_adv;

`ifdef ALU_ARB_RR_EN
    logic last_q;
    // on contention the requester that did not win last time goes first
    assign pick1 = req1_valid && (!req0_valid || !last_q);
`else
    assign pick1 = req1_valid && !req0_valid;
`endif
    assign pick0 = req0_valid && !pick1;

    assign req0_ready = !rst && s1_free && pick0;
    assign req1_ready = !rst && s1_free && pick1;
    assign accept     = req0_ready || req1_ready;

    assign s1_valid_d  = accept || (s1_valid_q && !s2_adv);
    assign rsp_valid_d = s2_adv || (rsp_valid_q && !rsp_ready);

    ex u_ex (
        .rst    (rst),
        .aluop  (s1_aluop_q),
        .alusel (s1_alusel_q),
        .op1    (s1_op1_q),
        .op2    (s1_op2_q),
        .result (ex_result),
        .illegal(ex_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q    <= 1'b0;
            s1_id_q       <= 1'b0;
            s1_op1_q      <= '0;
            s1_op2_q      <= '0;
            s1_aluop_q    <= '0;
            s1_alusel_q   <= '0;
            s1_tag_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_tag_q     <= '0;
            rsp_result_q  <= '0;
            rsp_illegal_q <= 1'b0;
`ifdef ALU_ARB_RR_EN
            last_q        <= 1'b1;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            rsp_valid_q <= rsp_valid_d;
            if (accept) begin
                s1_id_q     <= req1_ready;
                s1_op1_q    <= req1_ready ? req1_op1    : req0_op1;
                s1_op2_q    <= req1_ready ? req1_op2    : req0_op2;
                s1_aluop_q  <= req1_ready ? req1_aluop  : req0_aluop;
                s1_alusel_q <= req1_ready ? req1_alusel : req0_alusel;
                s1_tag_q    <= req1_ready ? req1_tag    : req0_tag;
`ifdef ALU_ARB_RR_EN
                last_q      <= req1_ready;
`endif
            end
            if (s2_adv) begin
                rsp_id_q      <= s1_id_q;
                rsp_tag_q     <= s1_tag_q;
                rsp_result_q  <= ex_illegal ? 64'd0 : ex_result;
                rsp_illegal_q <= ex_illegal;
            end
        end
    end

    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_tag     = rsp_tag_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_illegal = rsp_illegal_q;
endmodule

// File: tb/tb_alu_arb.sv
// Directed bench for alu_arb: single-op vector table plus contention, backpressure and reset sequences.

module tb_alu_arb;
    localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, XOR = 4'h2, OR = 4'h3, AND = 4'h4;
`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 0, rst = 1;
    logic        req0_valid = 0, req1_valid = 0, rsp_ready = 1;
    logic        req0_ready, req1_ready;
    logic [63:0] req0_op1 = 0, req0_op2 = 0, req1_op1 = 0, req1_op2 = 0;
    logic [7:0]  req0_aluop = 0, req1_aluop = 0;
    logic [3:0]  req0_alusel = 0, req1_alusel = 0, req0_tag = 0, req1_tag = 0;
    logic        rsp_valid, rsp_id, rsp_illegal;
    logic [3:0]  rsp_tag;
    logic [63:0] rsp_result;

    int errors = 0, checks = 0;

    always #5 clk = ~clk;

    alu_arb #(.TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_aluop(req0_aluop), .req0_alusel(req0_alusel), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_aluop(req1_aluop), .req1_alusel(req1_alusel), .req1_tag(req1_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .rsp_illegal(rsp_illegal)
    );

    typedef struct {
        logic        id;
        logic [3:0]  sel;
        logic [63:0] a, b;
        logic [3:0]  tag;
        logic [63:0] res;
        logic        ill;
    } vec_t;
    vec_t tbl[9];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // step to just after the next rising edge, where inputs are driven
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic id, input logic v, input logic [3:0] sel,
                         input logic [63:0] a, input logic [63:0] b, input logic [3:0] tag);
        if (id) begin
            req1_valid = v; req1_alusel = sel; req1_op1 = a; req1_op2 = b; req1_tag = tag; req1_aluop = 8'h33;
        end else begin
            req0_valid = v; req0_alusel = sel; req0_op1 = a; req0_op2 = b; req0_tag = tag; req0_aluop = 8'h33;
        end
    endtask

    task automatic do_reset();
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    logic [63:0] q_res[8];
    logic [3:0]  q_tag[8];
    logic        q_id[8];

    initial begin
        tbl[0] = '{0, ADD, 64'd5, 64'd3, 4'd2, 64'd8, 0};
        tbl[1] = '{1, SUB, 64'd0, 64'd1, 4'd7, 64'hFFFF_FFFF_FFFF_FFFF, 0};
        tbl[2] = '{0, ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 4'd9, 64'd0, 0};
        tbl[3] = '{1, 4'hF, 64'd5, 64'd6, 4'd3, 64'd0, 1};
        tbl[4] = '{0, XOR, 64'hF0F0_0000_1234_5678, 64'h0FF0_0000_FFFF_0000, 4'd4, 64'hFF00_0000_EDCB_5678, 0};
        tbl[5] = '{1, OR,  64'h8000_0000_0000_0001, 64'h0000_0000_0000_0100, 4'd5, 64'h8000_0000_0000_0101, 0};
        tbl[6] = '{0, AND, 64'hDEAD_BEEF_CAFE_F00D, 64'h0000_FFFF_0000_FFFF, 4'd6, 64'h0000_BEEF_0000_F00D, 0};
        tbl[7] = '{0, 4'h7, 64'h1234, 64'h1, 4'd15, 64'd0, 1};
        tbl[8] = '{1, SUB, 64'd100, 64'd42, 4'd1, 64'd58, 0};

        // reset: ready forced low even with a valid request
        req0_valid = 1;
        rst = 1;
        tick(); #2;
        chk("ready_in_reset", {63'd0, req0_ready}, 64'd0);
        tick(); req0_valid = 0; rst = 0; #2;
        chk("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        chk("rst_rsp_id", {63'd0, rsp_id}, 64'd0);
        chk("rst_rsp_tag", {60'd0, rsp_tag}, 64'd0);
        chk("rst_rsp_result", rsp_result, 64'd0);
        chk("rst_rsp_illegal", {63'd0, rsp_illegal}, 64'd0);

        // single-op vectors, one transaction at a time
        rsp_ready = 1;
        for (int i = 0; i < 9; i++) begin
            tick();
            drive(tbl[i].id, 1, tbl[i].sel, tbl[i].a, tbl[i].b, tbl[i].tag);
            #2;
            chk($sformatf("v%0d_ready", i), {63'd0, tbl[i].id ? req1_ready : req0_ready}, 64'd1);
            chk($sformatf("v%0d_other_ready", i), {63'd0, tbl[i].id ? req0_ready : req1_ready}, 64'd0);
            tick();
            drive(tbl[i].id, 0, 4'd0, 64'd0, 64'd0, 4'd0);
            #2;
            chk($sformatf("v%0d_lat", i), {63'd0, rsp_valid}, 64'd0);
            tick(); #2;
            chk($sformatf("v%0d_valid", i), {63'd0, rsp_valid}, 64'd1);
            chk($sformatf("v%0d_result", i), rsp_result, tbl[i].res);
            chk($sformatf("v%0d_id", i), {63'd0, rsp_id}, {63'd0, tbl[i].id});
            chk($sformatf("v%0d_tag", i), {60'd0, rsp_tag}, {60'd0, tbl[i].tag});
            chk($sformatf("v%0d_illegal", i), {63'd0, rsp_illegal}, {63'd0, tbl[i].ill});
        end
        tick(); #2;
        chk("drained", {63'd0, rsp_valid}, 64'd0);

        // contention: both valid for 4 accept cycles, rsp_ready high
        do_reset();
        begin
            int k0, k1, n;
            logic w;
            k0 = 0; k1 = 0; n = 0;
            for (int cyc = 0; cyc < 6; cyc++) begin
                if (cyc > 0) tick();
                drive(0, cyc < 4, ADD, 64'(k0), 64'd1, {1'b0, 3'(k0)});
                drive(1, cyc < 4, ADD, 64'(100 + k1), 64'd1, {1'b1, 3'(k1)});
                #2;
                if (cyc < 4) begin
                    w = RR ? cyc[0] : 1'b0;
                    chk($sformatf("cont%0d_r0", cyc), {63'd0, req0_ready}, {63'd0, !w});
                    chk($sformatf("cont%0d_r1", cyc), {63'd0, req1_ready}, {63'd0, w});
                    q_id[n] = w;
                    q_res[n] = w ? 64'(101 + k1) : 64'(k0 + 1);
                    q_tag[n] = w ? {1'b1, 3'(k1)} : {1'b0, 3'(k0)};
                    n++;
                    if (w) k1++; else k0++;
                end
                if (cyc >= 2) begin
                    chk($sformatf("cont%0d_rv", cyc), {63'd0, rsp_valid}, 64'd1);
                    chk($sformatf("cont%0d_id", cyc), {63'd0, rsp_id}, {63'd0, q_id[cyc-2]});
                    chk($sformatf("cont%0d_tag", cyc), {60'd0, rsp_tag}, {60'd0, q_tag[cyc-2]});
                    chk($sformatf("cont%0d_res", cyc), rsp_result, q_res[cyc-2]);
                end
            end
        end
        tick(); #2;
        chk("cont_drained", {63'd0, rsp_valid}, 64'd0);

        // backpressure: 3 ops offered while rsp_ready is low
        rsp_ready = 0;
        drive(0, 1, SUB, 64'd10, 64'd3, 4'd1); #2;
        chk("bp_acc0", {63'd0, req0_ready}, 64'd1);
        tick(); drive(0, 1, XOR, 64'hFF, 64'h0F, 4'd2); #2;
        chk("bp_acc1", {63'd0, req0_ready}, 64'd1);
        tick(); drive(0, 1, OR, 64'h100, 64'h001, 4'd3); #2;
        chk("bp_full", {63'd0, req0_ready}, 64'd0);
        chk("bp_rv", {63'd0, rsp_valid}, 64'd1);
        chk("bp_res_a", rsp_result, 64'd7);
        tick(); #2;
        chk("bp_full2", {63'd0, req0_ready}, 64'd0);
        chk("bp_hold_res", rsp_result, 64'd7);
        chk("bp_hold_tag", {60'd0, rsp_tag}, 64'd1);
        tick(); rsp_ready = 1; #2;
        chk("bp_reready", {63'd0, req0_ready}, 64'd1);
        chk("bp_res_first", rsp_result, 64'd7);
        tick(); drive(0, 0, ADD, 64'd0, 64'd0, 4'd0); #2;
        chk("bp_res_second", rsp_result, 64'hF0);
        chk("bp_tag_second", {60'd0, rsp_tag}, 64'd2);
        tick(); #2;
        chk("bp_res_third", rsp_result, 64'h101);
        chk("bp_tag_third", {60'd0, rsp_tag}, 64'd3);
        tick(); #2;
        chk("bp_drained", {63'd0, rsp_valid}, 64'd0);

        // reset mid-flight with S1 and S2 full
        rsp_ready = 0;
        drive(0, 1, ADD, 64'd1, 64'd1, 4'd8);
        tick(); drive(0, 1, ADD, 64'd2, 64'd2, 4'd9);
        tick(); drive(0, 0, ADD, 64'd0, 64'd0, 4'd0); #2;
        chk("mf_full_rv", {63'd0, rsp_valid}, 64'd1);
        rst = 1;
        drive(0, 1, ADD, 64'd3, 64'd3, 4'd10);
        drive(1, 1, ADD, 64'd4, 64'd4, 4'd11);
        #1;
        chk("mf_rst_r0", {63'd0, req0_ready}, 64'd0);
        chk("mf_rst_r1", {63'd0, req1_ready}, 64'd0);
        tick(); rst = 0;
        drive(0, 0, ADD, 64'd0, 64'd0, 4'd0);
        drive(1, 0, ADD, 64'd0, 64'd0, 4'd0);
        rsp_ready = 1;
        #2;
        chk("mf_rv0", {63'd0, rsp_valid}, 64'd0);
        tick(); #2;
        chk("mf_rv1", {63'd0, rsp_valid}, 64'd0);
        drive(0, 1, ADD, 64'd3, 64'd3, 4'd10);
        drive(1, 1, ADD, 64'd4, 64'd4, 4'd11);
        #1;
        chk("mf_cont_r0", {63'd0, req0_ready}, 64'd1);
        chk("mf_cont_r1", {63'd0, req1_ready}, 64'd0);
        tick();
        drive(0, 0, ADD, 64'd0, 64'd0, 4'd0);
        drive(1, 0, ADD, 64'd0, 64'd0, 4'd0);
        tick(); #2;
        chk("mf_rsp_id", {63'd0, rsp_id}, 64'd0);
        chk("mf_rsp_res", rsp_result, 64'd6);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
